// File: rtl/dmmu_trans.sv
// Data-side address translation: two-stage valid/ready pipeline with MIPS32
// segment decode, one TLB search port, and registered exception status.
module dmmu_trans #(
   parameter int TLBNUM = 16
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [31:0]               req_vaddr,
   input  logic                      req_wr,
   input  logic [7:0]                cp0_asid,
   input  logic                      flush,
   input  logic                      tlb_we,
   output logic [18:0]               s_vpn2,
   output logic                      s_odd_page,
   output logic [7:0]                s_asid,
   input  logic                      s_found,
   input  logic [$clog2(TLBNUM)-1:0] s_index,
   input  logic [19:0]               s_pfn,
   input  logic [2:0]                s_c,
   input  logic                      s_d,
   input  logic                      s_v,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [31:0]               rsp_paddr,
   output logic                      rsp_uncached,
   output logic                      rsp_ex,
   output logic                      rsp_refill,
   output logic [4:0]                rsp_excode,
   output logic [31:0]               rsp_badvaddr
);

   typedef enum logic [4:0] {
      EXC_NONE = 5'd0,
      EXC_MOD  = 5'd1,
      EXC_TLBL = 5'd2,
      EXC_TLBS = 5'd3
   } excode_e;

   logic        a_valid_q, a_valid_d;
   logic [31:0] a_vaddr_q, a_vaddr_d;
   logic        a_wr_q, a_wr_d;

   logic        b_valid_q, b_valid_d;
   logic [31:0] b_paddr_q, b_paddr_d;
   logic        b_uncached_q, b_uncached_d;
   logic        b_ex_q, b_ex_d;
   logic        b_refill_q, b_refill_d;
   excode_e     b_excode_q, b_excode_d;
   logic [31:0] b_badvaddr_q, b_badvaddr_d;

   logic        advance_a, advance_b, accept;
   logic [31:0] n_paddr;
   logic        n_uncached, n_ex, n_refill;
   excode_e     n_excode;
   logic        unused_index;

   assign unused_index = ^s_index;

   assign advance_b = !b_valid_q || rsp_ready;
   assign advance_a = a_valid_q && advance_b && !tlb_we;
   assign req_ready = !flush && (!a_valid_q || advance_a);
   assign accept    = req_valid && req_ready;

   assign s_vpn2     = a_vaddr_q[31:13];
   assign s_odd_page = a_vaddr_q[12];
   assign s_asid     = cp0_asid;

   // Translation of the request currently in stage A.
   always_comb begin
      n_paddr    = '0;
      n_uncached = 1'b0;
      n_ex       = 1'b0;
      n_refill   = 1'b0;
      n_excode   = EXC_NONE;
      if (a_vaddr_q[31:30] == 2'b10) begin
         n_paddr    = {3'b000, a_vaddr_q[28:0]};
         n_uncached = a_vaddr_q[29];
      end else if (!s_found) begin
         n_ex     = 1'b1;
         n_refill = 1'b1;
         n_excode = a_wr_q ? EXC_TLBS : EXC_TLBL;
      end else if (!s_v) begin
         n_ex     = 1'b1;
         n_excode = a_wr_q ? EXC_TLBS : EXC_TLBL;
      end else if (a_wr_q && !s_d) begin
         n_ex     = 1'b1;
         n_excode = EXC_MOD;
      end else begin
         n_paddr    = {s_pfn, a_vaddr_q[11:0]};
         n_uncached = (s_c == 3'd2);
      end
   end

   // Flush wins over every advance; B is refilled from A before A reloads.
   always_comb begin
      a_valid_d    = a_valid_q;
      a_vaddr_d    = a_vaddr_q;
      a_wr_d       = a_wr_q;
      b_valid_d    = b_valid_q;
      b_paddr_d    = b_paddr_q;
      b_uncached_d = b_uncached_q;
      b_ex_d       = b_ex_q;
      b_refill_d   = b_refill_q;
      b_excode_d   = b_excode_q;
      b_badvaddr_d = b_badvaddr_q;
      if (flush) begin
         a_valid_d = 1'b0;
         b_valid_d = 1'b0;
      end else begin
         if (advance_a) begin
            b_valid_d    = 1'b1;
            b_paddr_d    = n_paddr;
            b_uncached_d = n_uncached;
            b_ex_d       = n_ex;
            b_refill_d   = n_refill;
            b_excode_d   = n_excode;
            b_badvaddr_d = a_vaddr_q;
         end else if (advance_b) begin
            b_valid_d = 1'b0;
         end
         if (accept) begin
            a_valid_d = 1'b1;
            a_vaddr_d = req_vaddr;
            a_wr_d    = req_wr;
         end else if (advance_a) begin
            a_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         a_valid_q    <= 1'b0;
         a_vaddr_q    <= '0;
         a_wr_q       <= 1'b0;
         b_valid_q    <= 1'b0;
         b_paddr_q    <= '0;
         b_uncached_q <= 1'b0;
         b_ex_q       <= 1'b0;
         b_refill_q   <= 1'b0;
         b_excode_q   <= EXC_NONE;
         b_badvaddr_q <= '0;
      end else begin
         a_valid_q    <= a_valid_d;
         a_vaddr_q    <= a_vaddr_d;
         a_wr_q       <= a_wr_d;
         b_valid_q    <= b_valid_d;
         b_paddr_q    <= b_paddr_d;
         b_uncached_q <= b_uncached_d;
         b_ex_q       <= b_ex_d;
         b_refill_q   <= b_refill_d;
         b_excode_q   <= b_excode_d;
         b_badvaddr_q <= b_badvaddr_d;
      end
   end

   assign rsp_valid    = b_valid_q;
   assign rsp_paddr    = b_paddr_q;
   assign rsp_uncached = b_uncached_q;
   assign rsp_ex       = b_ex_q;
   assign rsp_refill   = b_refill_q;
   assign rsp_excode   = b_excode_q;
   assign rsp_badvaddr = b_badvaddr_q;

endmodule

// File: tb/tb_dmmu_trans.sv
// Bench for dmmu_trans: small TLB table, in-order response queue model,
// directed cases with literal expectations and a randomized phase.
module tb_dmmu_trans;

   logic        clk = 1'b0;
   logic        resetn, req_valid, req_ready, req_wr, flush, tlb_we;
   logic [31:0] req_vaddr;
   logic [7:0]  cp0_asid;
   logic [18:0] s_vpn2;
   logic        s_odd_page;
   logic [7:0]  s_asid;
   logic        s_found, s_d, s_v;
   logic [3:0]  s_index;
   logic [19:0] s_pfn;
   logic [2:0]  s_c;
   logic        rsp_valid, rsp_ready, rsp_uncached, rsp_ex, rsp_refill;
   logic [31:0] rsp_paddr, rsp_badvaddr;
   logic [4:0]  rsp_excode;

   dmmu_trans #(.TLBNUM(16)) dut (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
      .req_vaddr(req_vaddr), .req_wr(req_wr), .cp0_asid(cp0_asid), .flush(flush),
      .tlb_we(tlb_we), .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid),
      .s_found(s_found), .s_index(s_index), .s_pfn(s_pfn), .s_c(s_c), .s_d(s_d),
      .s_v(s_v), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_paddr(rsp_paddr),
      .rsp_uncached(rsp_uncached), .rsp_ex(rsp_ex), .rsp_refill(rsp_refill),
      .rsp_excode(rsp_excode), .rsp_badvaddr(rsp_badvaddr)
   );

   always #5 clk = ~clk;

   // TLB contents (4 entries, even/odd pages)
   logic [18:0] t_vpn2 [4];
   logic [7:0]  t_asid [4];
   logic        t_g    [4];
   logic [19:0] t_pfn  [4][2];
   logic [2:0]  t_c    [4][2];
   logic        t_d    [4][2];
   logic        t_v    [4][2];

   always_comb begin
      s_found = 1'b0; s_index = '0; s_pfn = '0; s_c = '0; s_d = 1'b0; s_v = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!s_found && t_vpn2[i] == s_vpn2 && (t_g[i] || t_asid[i] == s_asid)) begin
            s_found = 1'b1;
            s_index = 4'(i);
            s_pfn   = t_pfn[i][s_odd_page];
            s_c     = t_c[i][s_odd_page];
            s_d     = t_d[i][s_odd_page];
            s_v     = t_v[i][s_odd_page];
         end
      end
   end

   typedef struct {
      logic [31:0] vaddr;
      logic        wr;
      logic [31:0] paddr;
      logic        unc, ex, refill;
      logic [4:0]  excode;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0, n_err = 0, n_rsp = 0, wait_cnt = 0;
   logic last_acc = 1'b0, prev_stall = 1'b0;
   logic [31:0] p_paddr, p_bad;
   logic        p_unc, p_ex, p_ref;
   logic [4:0]  p_code;

   function automatic exp_t xlate(input logic [31:0] va, input logic wr, input logic [7:0] asid);
      exp_t e;
      int   hit;
      logic odd;
      e.vaddr = va; e.wr = wr; e.paddr = 0; e.unc = 0; e.ex = 0; e.refill = 0; e.excode = 0;
      if (va >= 32'h8000_0000 && va < 32'hC000_0000) begin
         e.paddr = va & 32'h1FFF_FFFF;
         e.unc   = (va >= 32'hA000_0000);
         return e;
      end
      hit = -1;
      odd = va[12];
      for (int i = 3; i >= 0; i--)
         if (t_vpn2[i] == va[31:13] && (t_g[i] || t_asid[i] == asid)) hit = i;
      if (hit < 0) begin
         e.ex = 1; e.refill = 1; e.excode = wr ? 5'd3 : 5'd2;
      end else if (!t_v[hit][odd]) begin
         e.ex = 1; e.excode = wr ? 5'd3 : 5'd2;
      end else if (wr && !t_d[hit][odd]) begin
         e.ex = 1; e.excode = 5'd1;
      end else begin
         e.paddr = t_pfn[hit][odd] * 32'h1000 + (va % 32'h1000);
         e.unc   = (t_c[hit][odd] == 3'd2);
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock cycle: sample after inputs settle, check, then advance the model.
   task automatic step();
      logic acc, hs;
      #1;
      acc = req_valid && req_ready;
      hs  = rsp_valid && rsp_ready;
      if (flush) chk("ready_in_flush", {31'b0, req_ready}, 0);
      if (rsp_valid) begin
         if (q.size() == 0) chk("spurious_rsp", {31'b0, rsp_valid}, 0);
         else begin
            chk("rsp_paddr", rsp_paddr, q[0].paddr);
            chk("rsp_uncached", {31'b0, rsp_uncached}, {31'b0, q[0].unc});
            chk("rsp_ex", {31'b0, rsp_ex}, {31'b0, q[0].ex});
            chk("rsp_refill", {31'b0, rsp_refill}, {31'b0, q[0].refill});
            chk("rsp_excode", {27'b0, rsp_excode}, {27'b0, q[0].excode});
            chk("rsp_badvaddr", rsp_badvaddr, q[0].vaddr);
         end
      end
      if (prev_stall) begin
         chk("stall_valid", {31'b0, rsp_valid}, 1);
         chk("stall_paddr", rsp_paddr, p_paddr);
         chk("stall_bad", rsp_badvaddr, p_bad);
         chk("stall_flags", {26'b0, rsp_uncached, rsp_ex, rsp_refill, rsp_excode[2:0]},
             {26'b0, p_unc, p_ex, p_ref, p_code[2:0]});
      end
      if (!resetn || flush) q.delete();
      else begin
         if (hs && q.size() > 0) void'(q.pop_front());
         if (acc) q.push_back(xlate(req_vaddr, req_wr, cp0_asid));
      end
      if (hs && resetn) n_rsp++;
      if (q.size() > 2) chk("occupancy", q.size(), 2);
      if (q.size() > 0 && !hs) wait_cnt++; else wait_cnt = 0;
      if (wait_cnt > 40) begin
         chk("rsp_timeout", wait_cnt, 40);
         wait_cnt = 0;
      end
      prev_stall = resetn && !flush && rsp_valid && !rsp_ready;
      p_paddr = rsp_paddr; p_bad = rsp_badvaddr; p_unc = rsp_uncached;
      p_ex = rsp_ex; p_ref = rsp_refill; p_code = rsp_excode;
      last_acc = acc && resetn && !flush;
      @(negedge clk);
   endtask

   task automatic drain();
      req_valid = 0; rsp_ready = 1; flush = 0; tlb_we = 0;
      for (int k = 0; k < 10 && q.size() > 0; k++) step();
      step();
      chk("drain_empty", q.size(), 0);
   endtask

   // Single request: acceptance, empty stage B one cycle later, response after two.
   task automatic one(input logic [31:0] va, input logic wr);
      req_valid = 1; req_vaddr = va; req_wr = wr; rsp_ready = 1;
      step();
      chk("accept", {31'b0, last_acc}, 1);
      req_valid = 0;
      chk("lat_n1", {31'b0, rsp_valid}, 0);
      step();
      chk("lat_n2", {31'b0, rsp_valid}, 1);
   endtask

   task automatic set_ent(input int i, input logic [18:0] vpn2, input logic g, input logic [7:0] asid,
                          input logic [19:0] pfn, input logic [2:0] c, input logic d, input logic v);
      t_vpn2[i] = vpn2; t_g[i] = g; t_asid[i] = asid;
      for (int p = 0; p < 2; p++) begin
         t_pfn[i][p] = pfn + 20'(p); t_c[i][p] = c; t_d[i][p] = d; t_v[i][p] = v;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got time %0t, expected completion", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int nsent, base_rsp;
      logic [31:0] va;
      resetn = 0; req_valid = 0; req_vaddr = 0; req_wr = 0; cp0_asid = 0;
      flush = 0; tlb_we = 0; rsp_ready = 1;
      set_ent(0, 19'h201, 1, 8'h00, 20'h12345, 3'd3, 1, 1);
      set_ent(1, 19'h300, 1, 8'h00, 20'h22220, 3'd3, 1, 0);
      set_ent(2, 19'h380, 1, 8'h00, 20'h33330, 3'd3, 0, 1);
      set_ent(3, 19'h3C0, 1, 8'h00, 20'h0ABCD, 3'd3, 1, 0);
      step(); step();
      resetn = 1;
      chk("rst_valid", {31'b0, rsp_valid}, 0);
      chk("rst_paddr", rsp_paddr, 0);
      #1 chk("rst_ready", {31'b0, req_ready}, 1);

      one(32'hA000_1234, 0);
      chk("k1_paddr", rsp_paddr, 32'h0000_1234);
      chk("k1_unc", {31'b0, rsp_uncached}, 1);
      chk("k1_ex", {31'b0, rsp_ex}, 0);
      step();
      one(32'h8000_1234, 0);
      chk("k0_paddr", rsp_paddr, 32'h0000_1234);
      chk("k0_unc", {31'b0, rsp_uncached}, 0);
      step();

      one(32'h0040_2ABC, 0);
      chk("hit_paddr", rsp_paddr, 32'h1234_5ABC);
      chk("hit_unc", {31'b0, rsp_uncached}, 0);
      step();
      t_c[0][0] = 3'd2;
      one(32'h0040_2ABC, 1);
      chk("hit_c2_unc", {31'b0, rsp_uncached}, 1);
      chk("hit_c2_ex", {31'b0, rsp_ex}, 0);
      step();

      one(32'h0040_0000, 0);
      chk("miss_ex", {31'b0, rsp_ex}, 1);
      chk("miss_refill", {31'b0, rsp_refill}, 1);
      chk("miss_code", {27'b0, rsp_excode}, 2);
      chk("miss_bad", rsp_badvaddr, 32'h0040_0000);
      chk("miss_paddr", rsp_paddr, 0);
      step();
      one(32'h0060_0000, 1);
      chk("inv_code", {27'b0, rsp_excode}, 3);
      chk("inv_refill", {31'b0, rsp_refill}, 0);
      step();
      one(32'h0070_0000, 1);
      chk("mod_code", {27'b0, rsp_excode}, 1);
      chk("mod_ex", {31'b0, rsp_ex}, 1);
      step();

      // Backpressure: only two requests fit while the consumer stalls.
      rsp_ready = 0; nsent = 0; base_rsp = n_rsp;
      for (int k = 0; k < 3; k++) begin
         req_valid = 1; req_wr = 0; req_vaddr = 32'hA000_0100 + 32'(nsent) * 16;
         step();
         if (last_acc) nsent++;
      end
      chk("bp_held", nsent, 2);
      rsp_ready = 1;
      for (int k = 0; k < 20 && nsent < 4; k++) begin
         req_valid = 1; req_vaddr = 32'hA000_0100 + 32'(nsent) * 16;
         step();
         if (last_acc) nsent++;
      end
      drain();
      chk("bp_count", n_rsp - base_rsp, 4);

      // TLB write while the request waits in stage A.
      req_valid = 1; req_vaddr = 32'h0078_0123; req_wr = 0;
      step();
      req_valid = 0; tlb_we = 1;
      step();
      t_v[3][0] = 1'b1;
      q[0] = xlate(q[0].vaddr, q[0].wr, cp0_asid);
      tlb_we = 0;
      chk("hz_hold", {31'b0, rsp_valid}, 0);
      step();
      chk("hz_valid", {31'b0, rsp_valid}, 1);
      chk("hz_paddr", rsp_paddr, 32'h0ABC_D123);
      chk("hz_ex", {31'b0, rsp_ex}, 0);
      step();

      // Flush with both stages full.
      rsp_ready = 0; base_rsp = n_rsp;
      req_valid = 1; req_vaddr = 32'hA000_0200; step();
      req_vaddr = 32'hA000_0300; step();
      chk("fl_full", {31'b0, rsp_valid}, 1);
      flush = 1; req_vaddr = 32'hA000_0400; step();
      flush = 0; req_valid = 0;
      chk("fl_valid", {31'b0, rsp_valid}, 0);
      rsp_ready = 1;
      repeat (4) step();
      chk("fl_stale", n_rsp - base_rsp, 0);

      // Reset mid-stream with both stages full.
      rsp_ready = 0;
      req_valid = 1; req_vaddr = 32'hA000_0500; step();
      req_vaddr = 32'hB000_0600; step();
      resetn = 0; req_valid = 0; step();
      resetn = 1;
      chk("mrst_valid", {31'b0, rsp_valid}, 0);
      chk("mrst_paddr", rsp_paddr, 0);
      chk("mrst_bad", rsp_badvaddr, 0);
      chk("mrst_flags", {27'b0, rsp_uncached, rsp_ex, rsp_refill, rsp_excode[1:0]}, 0);
      #1 chk("mrst_ready", {31'b0, req_ready}, 1);
      rsp_ready = 1;
      repeat (3) step();

      // Randomized phase: fixed ASID and TLB contents, random handshakes and hazards.
      cp0_asid = 8'h05;
      set_ent(1, 19'h300, 0, 8'h05, 20'h0, 3'd3, 1, 1);
      set_ent(2, 19'h380, 0, 8'h07, 20'h0, 3'd3, 1, 1);
      for (int i = 0; i < 4; i++)
         for (int p = 0; p < 2; p++) begin
            t_pfn[i][p] = 20'($urandom);
            t_c[i][p]   = 3'($urandom_range(0, 3));
            t_d[i][p]   = 1'($urandom_range(0, 3) != 0);
            t_v[i][p]   = 1'($urandom_range(0, 3) != 0);
         end
      for (int n = 0; n < 2000; n++) begin
         case ($urandom_range(0, 5))
            0: va = {3'b100, 29'($urandom)};
            1: va = {3'b101, 29'($urandom)};
            5: va = $urandom;
            default: va = {t_vpn2[$urandom_range(0, 3)], 13'($urandom)};
         endcase
         if (!last_acc || !req_valid) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_vaddr = va;
            req_wr    = 1'($urandom);
         end
         rsp_ready = ($urandom_range(0, 9) < 7);
         tlb_we    = ($urandom_range(0, 9) == 0);
         flush     = ($urandom_range(0, 99) < 3);
         resetn    = ($urandom_range(0, 99) != 0);
         step();
      end
      resetn = 1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dmmu_trans.md
# dmmu_trans

Data-side address translation stage between the memory-stage address generator and the data cache/AXI bridge. Accepts virtual load/store requests, classifies them by MIPS32 segment, drives one TLB search port for mapped segments, and returns a registered physical address with cacheability and TLB exception status. It is a two-stage, fully pipelined valid/ready block: one request per cycle with backpressure, flush and TLB-write hazard hold.

## Interface
- TLBNUM, 16, TLB entry count; sets the s_index width to $clog2(TLBNUM).
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_vaddr  in  32  virtual address.
- req_wr  in  1  1 = store, 0 = load.
- cp0_asid  in  8  current EntryHi.ASID, sampled combinationally during the lookup cycle.
- flush  in  1  exception/ERET flush; kills all in-flight requests.
- tlb_we  in  1  TLB write-port enable (TLBWI/TLBWR this cycle).
- s_vpn2  out  19  TLB search VPN2.
- s_odd_page  out  1  TLB search odd-page select.
- s_asid  out  8  TLB search ASID.
- s_found  in  1  TLB hit.
- s_index  in  $clog2(TLBNUM)  hit index (unused; reserved for debug).
- s_pfn  in  20  PFN from the TLB.
- s_c  in  3  cache attribute from the TLB.
- s_d  in  1  dirty bit from the TLB.
- s_v  in  1  valid bit from the TLB.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer ready.
- rsp_paddr  out  32  physical address; 0 when rsp_ex = 1.
- rsp_uncached  out  1  1 = uncached access.
- rsp_ex  out  1  translation exception.
- rsp_refill  out  1  1 = TLB miss (refill vector); 0 = invalid or Mod.
- rsp_excode  out  5  1 = Mod, 2 = TLBL, 3 = TLBS; 0 when no exception.
- rsp_badvaddr  out  32  the request's vaddr; always valid alongside rsp_valid.

## Operation
- Stage A register (a_valid, a_vaddr, a_wr) is loaded on handshake. The TLB search runs from stage A: s_vpn2 = a_vaddr[31:13], s_odd_page = a_vaddr[12], s_asid = cp0_asid.
- Stage B register holds the response fields and is loaded from stage A when stage A advances.
- Segment decode on a_vaddr[31:28]:
  - kseg1 (0xA–0xB): unmapped; paddr = vaddr & 0x1FFFFFFF; uncached = 1.
  - kseg0 (0x8–0x9): unmapped; paddr = vaddr & 0x1FFFFFFF; uncached = 0.
  - All other segments: mapped.
- Mapped request outcomes, in priority order:
  - !s_found → ex = 1, refill = 1, excode = a_wr ? 3 : 2.
  - s_found && !s_v → ex = 1, refill = 0, excode = a_wr ? 3 : 2.
  - s_found && s_v && a_wr && !s_d → ex = 1, refill = 0, excode = 1.
  - Otherwise → paddr = {s_pfn, a_vaddr[11:0]}, uncached = (s_c == 3'd2), ex = 0.
- Unmapped requests never raise exceptions and ignore all TLB inputs.
- advance_b = !b_valid || rsp_ready.
- advance_a = a_valid && advance_b && !tlb_we.
- req_ready = !flush && (!a_valid || advance_a).
- TLB-write hazard: while tlb_we = 1, stage A holds, and its lookup repeats next cycle against the updated TLB contents. This applies to unmapped requests too, which keeps the rule simple.

## Timing
- Latency: a request accepted at edge N drives the search during cycle N+1. Its response is valid from cycle N+2, or later under backpressure or tlb_we.
- Throughput: 1 request per cycle when rsp_ready = 1 and tlb_we = 0.
- Stage B holds all response fields stable while rsp_valid && !rsp_ready.
- Reset (resetn = 0 at an edge): a_valid = 0, b_valid = 0, and all rsp_* fields = 0. This holds mid-operation too; in-flight requests are dropped. req_ready = 1 in the first cycle after reset (flush = 0).
- Flush at an edge: a_valid and b_valid are cleared. No request is accepted in the flush cycle. Flush has priority over every advance.
- Simultaneous rsp handshake and new acceptance in the same cycle is legal: B takes A, and A takes the new request.
- When stage B is full and stalled, stage A may still accept one request; req_ready then falls.

## Test plan
- Unmapped: load 0xA0001234 → rsp_paddr = 0x00001234, uncached = 1, ex = 0, valid 2 cycles after acceptance. Load 0x80001234 → same paddr, uncached = 0.
- Mapped hit: TLB model returns found = 1, v = 1, d = 1, pfn = 0x12345, c = 3 for vaddr 0x00402ABC → paddr = 0x12345ABC, uncached = 0. Repeat with c = 2 → uncached = 1.
- Exceptions:
  - Miss on load 0x00400000 → ex = 1, refill = 1, excode = 2, badvaddr = 0x00400000.
  - Store with v = 0 → excode = 3, refill = 0.
  - Store with v = 1, d = 0 → excode = 1.
- Backpressure: 4 back-to-back requests with rsp_ready low for 3 cycles → at most 2 requests held. Responses emerge in order with no loss or duplication, and fields stay stable while stalled.
- Hazard/flush:
  - tlb_we pulsed while a mapped request sits in A, TLB entry changed from v = 0 to v = 1 → response is a hit.
  - flush with both stages full → rsp_valid = 0 next cycle and no stale response appears.
- Reset mid-stream: resetn low for 1 cycle with both stages full → the next cycle has rsp_valid = 0, req_ready = 1, and all rsp fields = 0.
